complex_div: RTL and testbench
==============================

Name: complex_div

Overview:
- Iterative fixed-point complex divider: computes (a + jb) / (c + jd) and returns real part y and imaginary part z.
- Performs the inverse operation of the pipelined complex multiply/add ALU in the same design.
- Uses the same signed 16-bit operand format.
- Multi-cycle block with ready/valid handshakes on both input and output; one operation in flight at a time.

Parameters:
- FRAC_BITS, 8, number of fractional bits in y/z; legal range 0..15.
- ITER, 32+FRAC_BITS, number of divide iterations; derived, must not be overridden.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operands a..d valid
- in_ready  out  1  block can accept operands
- a, b, c, d  in  16 each, signed  numerator a+jb, denominator c+jd
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  downstream accepts result
- y  out  32 signed  real quotient, Q(31-FRAC_BITS).FRAC_BITS
- z  out  32 signed  imaginary quotient, same format
- div_by_zero  out  1  qualifies the current result: c = d = 0

Behaviour:
- Reset (async assert, sync release): state IDLE; in_ready=1; out_valid=0; y=z=0; div_by_zero=0; all internal registers cleared.
- Reset mid-operation: operation discarded, no partial result is ever presented.
- Arithmetic:
  - nr = a*c + b*d (signed 33b)
  - ni = b*c - a*d (signed 33b)
  - den = c*c + d*d (unsigned 32b)
  - y = trunc_toward_zero(nr * 2^FRAC_BITS / den); z likewise with ni.
  - Division runs on magnitudes; the sign is reapplied at the end.
  - |quotient| <= 2^(15.5+FRAC_BITS), so no saturation is needed for legal FRAC_BITS.
- FSM states IDLE, MULT, DIV, DONE:
  - IDLE: in_ready=1. On in_valid=1, latch a..d and go to MULT. This edge is T0.
  - MULT: in_ready=0. Register |nr|, |ni|, sign bits and den; load iteration counter = ITER.
    - If den == 0: go to DONE with y=z=0, div_by_zero=1 (out_valid at T0+2).
    - Else go to DIV.
  - DIV: one restoring-division step per cycle, real and imaginary in parallel, shared den.
    - Dividend = magnitude << FRAC_BITS, width ITER.
    - Counter decrements each cycle; after ITER steps, apply signs, register y/z, div_by_zero=0, go to DONE.
    - out_valid rises at edge T0+ITER+2 (42 cycles for FRAC_BITS=8).
  - DONE: out_valid=1; y, z and div_by_zero stable. in_ready=0, so in_valid is ignored.
    - On out_ready=1: go to IDLE next edge; out_valid falls and in_ready rises.
- Throughput: a new accept is possible no earlier than the edge after the result handshake; no back-to-back overlap.
- y/z hold their last value in IDLE; only out_valid qualifies them.
- out_ready while not in DONE is ignored.
- in_valid outside IDLE is ignored; no operand is captured or queued.

Decomposition:
- Shared package complex_pkg:
  - state enum cdiv_state_e {IDLE, MULT, DIV, DONE}
  - localparams OPW=16, PRODW=33, DENW=32, QW=32
- Sub-module udiv_iter:
  - Unsigned restoring-division datapath: remainder/quotient registers, one step per enabled cycle, parameterised by dividend width.
  - Instantiated twice (real, imaginary).
  - Sequencing and the FSM stay in complex_div.

Test Plan:
- Basic divide: (a,b,c,d)=(6,8,3,4) -> nr=50, ni=0, den=25 -> y=512 (2.0), z=0, div_by_zero=0, out_valid exactly 42 cycles after accept edge.
- Imaginary-only result: (1,0,0,1) -> y=0, z=-256 (1/j = -j).
- Truncation toward zero:
  - (1,0,3,0) -> y=85, z=0.
  - (-1,0,3,0) -> y=-85 (not -86).
- Divide-by-zero: (5,7,0,0) -> y=z=0, div_by_zero=1, out_valid 2 cycles after accept.
  - Next operation (6,8,3,4) -> div_by_zero=0, y=512.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid, and pulse in_valid with different operands -> y/z stable, in_ready=0, pulsed operands not captured.
  - Then out_ready=1 -> out_valid=0 and in_ready=1 on the next edge.
- Reset mid-DIV plus extremes:
  - Drop rst_n during iteration 20 -> out_valid=0 and in_ready=1 immediately; no result emitted.
  - After release, (-32768,-32768,-32768,-32768) -> y=256, z=0.
  - Random run against a golden model, with and without backpressure.

Source files
------------

// File: rtl/complex_pkg.sv
// Shared types and widths for the complex divider.
package complex_pkg;

  localparam int OPW   = 16;  // operand width (signed)
  localparam int PRODW = 33;  // width of a*c + b*d style sums (signed)
  localparam int DENW  = 32;  // width of c*c + d*d (unsigned)
  localparam int QW    = 32;  // quotient output width (signed)

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } cdiv_state_e;

endpackage

// File: rtl/udiv_iter.sv
// Unsigned restoring divider: one quotient bit per enabled cycle.
// After W enabled cycles following a load, quot_o holds dividend / divisor.
module udiv_iter
  import complex_pkg::*;
#(
  parameter int W = 40
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            en_i,
  input  logic [W-1:0]    dividend_i,
  input  logic [DENW-1:0] divisor_i,
  output logic [W-1:0]    quot_o
);

  logic [W-1:0]    quot_q, quot_d;
  logic [DENW-1:0] rem_q, rem_d;
  logic [DENW:0]   trial;
  logic [DENW:0]   diff;

  // Shift the next dividend bit into the remainder and subtract the divisor when it fits.
  always_comb begin
    rem_d  = rem_q;
    quot_d = quot_q;
    trial  = {rem_q, quot_q[W-1]};
    diff   = trial - {1'b0, divisor_i};
    if (load_i) begin
      rem_d  = '0;
      quot_d = dividend_i;
    end else if (en_i) begin
      if (trial >= {1'b0, divisor_i}) begin
        rem_d  = diff[DENW-1:0];
        quot_d = {quot_q[W-2:0], 1'b1};
      end else begin
        rem_d  = trial[DENW-1:0];
        quot_d = {quot_q[W-2:0], 1'b0};
      end
    end
  end

  // Remainder / quotient registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quot_q <= '0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
    end
  end

  assign quot_o = quot_q;

endmodule

// File: rtl/complex_div.sv
// Iterative fixed-point complex divider: (a + jb) / (c + jd) -> y + jz.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; out_valid stays high with stable y/z/div_by_zero until accepted.
module complex_div
  import complex_pkg::*;
#(
  parameter int FRAC_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [OPW-1:0] a,
  input  logic signed [OPW-1:0] b,
  input  logic signed [OPW-1:0] c,
  input  logic signed [OPW-1:0] d,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [QW-1:0]  y,
  output logic signed [QW-1:0]  z,
  output logic                  div_by_zero,
  output cdiv_state_e           dbg_state_o
);

  // Dividend carries FRAC_BITS extra low bits so the quotient lands in fixed point.
  localparam int ITER = 32 + FRAC_BITS;
  localparam int CNTW = $clog2(ITER + 1);

  cdiv_state_e           state_q;
  logic signed [OPW-1:0] a_q, b_q, c_q, d_q;
  logic [DENW-1:0]       den_q;
  logic                  neg_r_q, neg_i_q;
  logic [CNTW-1:0]       cnt_q;
  logic                  in_ready_q, out_valid_q, dz_q;
  logic signed [QW-1:0]  y_q, z_q;

  logic signed [PRODW-1:0] ax, bx, cx, dx;
  logic signed [PRODW-1:0] nr, ni;
  logic [DENW-1:0]         den_c, mag_r, mag_i;
  logic [ITER-1:0]         quot_r, quot_i;
  logic [QW-1:0]           q_r, q_i;
  logic                    div_load, div_en;

  // Products from the latched operands; magnitudes feed the unsigned dividers.
  always_comb begin
    ax    = PRODW'(a_q);
    bx    = PRODW'(b_q);
    cx    = PRODW'(c_q);
    dx    = PRODW'(d_q);
    nr    = ax * cx + bx * dx;
    ni    = bx * cx - ax * dx;
    den_c = DENW'(cx * cx + dx * dx);
    mag_r = nr[PRODW-1] ? DENW'(-nr) : DENW'(nr);
    mag_i = ni[PRODW-1] ? DENW'(-ni) : DENW'(ni);
    q_r   = QW'(quot_r);
    q_i   = QW'(quot_i);
  end

  assign div_load = (state_q == MULT);
  assign div_en   = (state_q == DIV) && (den_q != '0) && (cnt_q != '0);

  udiv_iter #(.W(ITER)) u_div_r (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (div_load),
    .en_i       (div_en),
    .dividend_i (ITER'(mag_r) << FRAC_BITS),
    .divisor_i  (den_q),
    .quot_o     (quot_r)
  );

  udiv_iter #(.W(ITER)) u_div_i (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (div_load),
    .en_i       (div_en),
    .dividend_i (ITER'(mag_i) << FRAC_BITS),
    .divisor_i  (den_q),
    .quot_o     (quot_i)
  );

  // Sequencing FSM with registered handshake and result outputs.
  // A zero denominator is caught on the first DIV cycle from the registered
  // den, so the flagged result appears two edges after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      den_q       <= '0;
      neg_r_q     <= 1'b0;
      neg_i_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dz_q        <= 1'b0;
      y_q         <= '0;
      z_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            c_q        <= c;
            d_q        <= d;
            in_ready_q <= 1'b0;
            state_q    <= MULT;
          end
        end
        MULT: begin
          den_q   <= den_c;
          neg_r_q <= nr[PRODW-1];
          neg_i_q <= ni[PRODW-1];
          cnt_q   <= CNTW'(ITER);
          state_q <= DIV;
        end
        DIV: begin
          if (den_q == '0) begin
            y_q         <= '0;
            z_q         <= '0;
            dz_q        <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            y_q         <= neg_r_q ? QW'(-q_r) : q_r;
            z_q         <= neg_i_q ? QW'(-q_i) : q_i;
            dz_q        <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign y           = y_q;
  assign z           = z_q;
  assign div_by_zero = dz_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_complex_div.sv
// Self-checking bench for complex_div with directed cases and a randomized run.
module tb_complex_div;
  import complex_pkg::*;

  localparam int F    = 8;
  localparam int ITER = 32 + F;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] a, b, c, d;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] y, z;
  logic               div_by_zero;
  cdiv_state_e        dbg_state;

  int total = 0;
  int bad   = 0;

  complex_div #(.FRAC_BITS(F)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .c           (c),
    .d           (d),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .y           (y),
    .z           (z),
    .div_by_zero (div_by_zero),
    .dbg_state_o (dbg_state)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: exact complex quotient, fixed point, truncated toward zero.
  function automatic void model(input int ia, input int ib, input int ic, input int id,
                                output int ey, output int ez, output bit edz);
    longint nr, ni, den;
    nr  = longint'(ia) * ic + longint'(ib) * id;
    ni  = longint'(ib) * ic - longint'(ia) * id;
    den = longint'(ic) * ic + longint'(id) * id;
    if (den == 0) begin
      ey = 0; ez = 0; edz = 1'b1;
    end else begin
      ey  = int'((nr * (longint'(1) << F)) / den);
      ez  = int'((ni * (longint'(1) << F)) / den);
      edz = 1'b0;
    end
  endfunction

  // Driver: wait for in_ready, present operands for one accepted edge.
  task automatic send(input int ia, input int ib, input int ic, input int id);
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
    end
    a = 16'(ia); b = 16'(ib); c = 16'(ic); d = 16'(id);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Driver: count edges after the accept edge until out_valid is seen.
  task automatic collect(output int lat);
    lat = 0;
    while (1) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
      if (lat > 200) begin
        total++; bad++;
        $display("FAIL collect_timeout out_valid=%0b required=1", out_valid);
        break;
      end
    end
  endtask

  // Driver: one-cycle out_ready pulse.
  task automatic accept();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || y !== 32'sd0 || z !== 32'sd0 ||
        div_by_zero !== 1'b0 || dbg_state !== IDLE) begin
      bad++;
      $display("FAIL reset in_ready=%0b out_valid=%0b y=%0d z=%0d dz=%0b state=%0d required 1 0 0 0 0 IDLE",
               in_ready, out_valid, y, z, div_by_zero, dbg_state);
    end
  endtask

  // Directed case with spec-given expected values and latency.
  task automatic directed(input string name, input int ia, input int ib, input int ic, input int id,
                          input int ey, input int ez, input bit edz, input int elat);
    int lat;
    send(ia, ib, ic, id);
    collect(lat);
    total++;
    if (y !== ey || z !== ez || div_by_zero !== edz) begin
      bad++;
      $display("FAIL %s y=%0d z=%0d dz=%0b required y=%0d z=%0d dz=%0b", name, y, z, div_by_zero, ey, ez, edz);
    end
    total++;
    if (lat !== elat) begin
      bad++;
      $display("FAIL %s_latency got=%0d required=%0d", name, lat, elat);
    end
    accept();
  endtask

  task automatic test_basic();
    directed("basic", 6, 8, 3, 4, 512, 0, 1'b0, ITER + 2);
  endtask

  task automatic test_imag();
    directed("imag_only", 1, 0, 0, 1, 0, -256, 1'b0, ITER + 2);
  endtask

  task automatic test_trunc();
    directed("trunc_pos", 1, 0, 3, 0, 85, 0, 1'b0, ITER + 2);
    directed("trunc_neg", -1, 0, 3, 0, -85, 0, 1'b0, ITER + 2);
  endtask

  task automatic test_div_zero();
    directed("div_zero", 5, 7, 0, 0, 0, 0, 1'b1, 2);
    directed("after_zero", 6, 8, 3, 4, 512, 0, 1'b0, ITER + 2);
  endtask

  task automatic test_backpressure();
    int lat, ey, ez;
    bit edz;
    model(100, -50, 7, 3, ey, ez, edz);
    send(100, -50, 7, 3);
    collect(lat);
    for (int i = 0; i < 10; i++) begin
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || y !== ey || z !== ez || div_by_zero !== edz) begin
        bad++;
        $display("FAIL hold[%0d] out_valid=%0b in_ready=%0b y=%0d z=%0d required 1 0 y=%0d z=%0d",
                 i, out_valid, in_ready, y, z, ey, ez);
      end
      a = 16'($urandom_range(0, 65535)); b = 16'($urandom_range(0, 65535));
      c = 16'($urandom_range(1, 100));   d = 16'($urandom_range(0, 100));
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL release out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
    end
    repeat (5) @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dbg_state !== IDLE) begin
      bad++;
      $display("FAIL not_captured out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    send(6, 8, 3, 4);
    repeat (22) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || y !== 32'sd0 || dbg_state !== IDLE) begin
      bad++;
      $display("FAIL reset_mid out_valid=%0b in_ready=%0b y=%0d required 0 1 0", out_valid, in_ready, y);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL reset_no_result out_valid_cycles=%0d required=0", seen);
    end
    directed("extreme", -32768, -32768, -32768, -32768, 256, 0, 1'b0, ITER + 2);
  endtask

  task automatic test_random(input int n, input bit bp);
    int ia, ib, ic, id, ey, ez, lat, elat;
    bit edz;
    for (int i = 0; i < n; i++) begin
      ia = int'($signed(16'($urandom_range(0, 65535))));
      ib = int'($signed(16'($urandom_range(0, 65535))));
      if ($urandom_range(0, 7) == 0) begin
        ic = 0; id = 0;
      end else begin
        ic = int'($signed(16'($urandom_range(0, 65535))));
        id = ($urandom_range(0, 3) == 0) ? int'($signed(16'($urandom_range(0, 15))))
                                         : int'($signed(16'($urandom_range(0, 65535))));
      end
      model(ia, ib, ic, id, ey, ez, edz);
      elat = edz ? 2 : ITER + 2;
      send(ia, ib, ic, id);
      collect(lat);
      if (bp) repeat ($urandom_range(0, 4)) @(negedge clk);
      total++;
      if (y !== ey || z !== ez || div_by_zero !== edz || lat !== elat) begin
        bad++;
        $display("FAIL rand[%0d] op=(%0d,%0d,%0d,%0d) y=%0d z=%0d dz=%0b lat=%0d required y=%0d z=%0d dz=%0b lat=%0d",
                 i, ia, ib, ic, id, y, z, div_by_zero, lat, ey, ez, edz, elat);
      end
      accept();
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c = '0; d = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    test_reset();
    test_basic();
    test_imag();
    test_trunc();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_random(40, 1'b0);
    test_random(40, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
